// File: rtl/kolum_pkg.sv
// rtl/kolum_pkg.sv - shared register-file constants and helpers for the write-back stage
package kolum_pkg;
    localparam int               REG_ADDR_W    = 4;
    localparam int               NUM_ARCH_REGS = 15;
    localparam logic [REG_ADDR_W-1:0] REG_PC   = 4'd15;

    function automatic logic is_pc(input logic [REG_ADDR_W-1:0] addr);
        return addr == REG_PC;
    endfunction
endpackage

// File: rtl/wb_result_mux.sv
// rtl/wb_result_mux.sv - 2:1 write-back result select (loaded data vs ALU result)
module wb_result_mux #(
    parameter int Width = 32
) (
    input  logic             i_mem_read,
    input  logic [Width-1:0] i_alu_res,
    input  logic [Width-1:0] i_data_mem,
    output logic [Width-1:0] o_result
);
    assign o_result = i_mem_read ? i_data_mem : i_alu_res;
endmodule

// File: rtl/wb_stage_regfile.sv
// rtl/wb_stage_regfile.sv - write-back commit, R0-R14 register file, PC-mapped R15, retire counter (WB_BYPASS_EN)
module wb_stage_regfile
    import kolum_pkg::*;
#(
    parameter int Width    = 32,
    parameter int CntWidth = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  wb_enable_in,
    input  logic                  mem_read_in,
    input  logic [Width-1:0]      alu_res_in,
    input  logic [Width-1:0]      data_mem_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [31:0]           pc_id_in,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    output logic [Width-1:0]      val1,
    output logic [Width-1:0]      val2,
    output logic [Width-1:0]      wb_value_out,
    output logic                  pc_write_err,
    output logic [CntWidth-1:0]   wb_count
);
    logic [Width-1:0]    r_regs [NUM_ARCH_REGS];
    logic [CntWidth-1:0] r_count;
    logic                r_pc_write_err;

    logic [Width-1:0]    w_wb_value;
    logic                w_wr_req;
    logic                w_commit;
    logic                w_pc_write;

    wb_result_mux #(.Width(Width)) u_result_mux (
        .i_mem_read (mem_read_in),
        .i_alu_res  (alu_res_in),
        .i_data_mem (data_mem_in),
        .o_result   (w_wb_value)
    );

    assign w_wr_req   = en && wb_enable_in;
    assign w_commit   = w_wr_req && !is_pc(dest_in);
    assign w_pc_write = w_wr_req && is_pc(dest_in);

    // Reset wins over a commit arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_count        <= '0;
            r_pc_write_err <= 1'b0;
        end else begin
            if (w_commit) begin
                r_regs[dest_in] <= w_wb_value;
                r_count         <= r_count + CntWidth'(1);
            end
            r_pc_write_err <= w_pc_write;
        end
    end

    // R15 is the PC and never lives in the array.
    function automatic logic [Width-1:0] read_port(input logic [REG_ADDR_W-1:0] addr);
        if (is_pc(addr)) begin
            return Width'(pc_id_in);
        end
`ifdef WB_BYPASS_EN
        if (w_commit && (addr == dest_in)) begin
            return w_wb_value;
        end
`endif
        return r_regs[addr];
    endfunction

    assign val1         = read_port(src1);
    assign val2         = read_port(src2);
    assign wb_value_out = w_wb_value;
    assign pc_write_err = r_pc_write_err;
    assign wb_count     = r_count;
endmodule
